sa_psum_drain: RTL and testbench
================================

// Module: sa_psum_drain
// PURPOSE
//  Receiving end of the PE column output (o_weight_psum) at the bottom edge of the systolic array.
//  - Captures per-column psums, which arrive one cycle apart per column (column c lags column 0 by c cycles).
//  - De-skews them into one aligned output row.
//  - Buffers rows in a FIFO and hands them off over a valid/ready interface.
//  - The array has no stall, so the drain absorbs backpressure and flags overflow instead of stalling.
// PARAMETERS
//  ADD_DATAWIDTH  32  width of one psum (same as PE ADD_DATAWIDTH)
//  NUM_COLS       4   array columns = psum lanes per output row (>=1)
//  FIFO_DEPTH     4   aligned rows buffered (power of 2, >=2)
// PORTS
//  clk            in   1                        clock; all logic on posedge
//  rst_n          in   1                        reset, synchronous, active-low
//  i_mode         in   1                        sa_pkg::sa_mode_e: 0 PRELOAD, 1 COMPUTE
//  i_clear        in   1                        synchronous flush (deskew, FIFO, overflow)
//  i_psum_valid   in   1                        column-0 psum of a new row is on i_psum[0] this cycle
//  i_psum         in   NUM_COLS*ADD_DATAWIDTH   bottom-row PE o_weight_psum, lane c = col c
//  o_valid        out  1                        o_data holds the FIFO head row
//  i_ready        in   1                        consumer accepts the head row when o_valid & i_ready
//  o_data         out  NUM_COLS*ADD_DATAWIDTH   aligned row, lane c = column c
//  o_count        out  $clog2(FIFO_DEPTH)+1     FIFO occupancy
//  o_overflow     out  1                        sticky: a completed row was dropped
// BEHAVIOUR
//  Reset (rst_n=0 at posedge) and i_clear (i_clear=1 at posedge) have the same effect:
//   - all valid flags, FIFO pointers and o_count go to 0.
//   - o_valid=0, o_overflow=0, o_data=0.
//   - In-flight rows are discarded. i_clear takes priority over any push or pop in the same cycle.
//  Capture:
//   - A row is launched when i_psum_valid & i_mode==COMPUTE. i_psum_valid is ignored in PRELOAD.
//   - A valid tag moves along a shift register of NUM_COLS-1 stages.
//   - Lane c is sampled on the cycle its tag is at stage c, i.e. c cycles after launch.
//   - Lane c is then held in (NUM_COLS-1-c) delay registers, so all lanes align on cycle t+NUM_COLS-1.
//   - Back-to-back launches (one per cycle) are supported; the tag pipeline is fully pipelined.
//   - The controller keeps i_mode=1 for NUM_COLS-1 cycles after the last launch. Lane sampling is gated by the tag, not by i_mode.
//  Push: on cycle t+NUM_COLS-1 the aligned row is written to the FIFO.
//   - If the FIFO is full and no pop occurs that cycle, the row is dropped and o_overflow sets (stays set until reset or i_clear).
//   - Full with a simultaneous pop: the push is accepted and o_count is unchanged.
//  Latency: launch at cycle t with the FIFO empty -> o_valid=1 at cycle t+NUM_COLS, o_data = aligned row.
//  Handshake:
//   - Once o_valid=1, o_data holds stable until accepted.
//   - Pop on o_valid & i_ready.
//   - No combinational path from i_ready to o_valid.
//   - Empty FIFO: o_valid=0, and i_ready is ignored.
//  Arithmetic: none; psums pass bit-exact, no sign or width change. NUM_COLS=1 means zero deskew stages (push on launch cycle).
//  Order: rows leave in launch order; wrap-around of the FIFO pointers is transparent.
// STRUCTURE
//  sa_pkg: typedef enum logic {SA_PRELOAD=1'b0, SA_COMPUTE=1'b1} sa_mode_e; psum_row_t packed array typedef.
//  Sub-module sa_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) holds the row buffer.
//  Deskew tag pipeline and lane delay lines live in sa_psum_drain via generate loops.
// TESTING (NUM_COLS=4, ADD_DATAWIDTH=32, FIFO_DEPTH=4)
//  1 Single row: launch at cycle 10, lane c driven 0x100+c on cycle 10+c, i_ready=1 -> o_valid only on cycle 14,
//    o_data={0x103,0x102,0x101,0x100}.
//  2 Streaming: 8 launches on consecutive cycles, lane c = 16*m+c for row m, i_ready=1 -> 8 rows in order
//    on cycles 14..21, o_overflow=0.
//  3 Backpressure: i_ready=0, 5 rows launched -> o_count=4, o_overflow=1, first 4 rows kept. i_ready=1 -> those 4 drain
//    in order, then o_valid=0.
//  4 Full + pop: FIFO full, push and pop on the same cycle -> o_count stays 4, o_overflow stays 0, no row lost.
//  5 Mode gate: i_psum_valid=1 while i_mode=0 for 6 cycles -> o_count stays 0, o_valid never asserts.
//  6 Flush: i_clear (and separately rst_n=0) at cycle 12 with 2 rows in flight and 2 queued -> next cycle o_count=0,
//    o_valid=0, o_overflow=0, no stale row emitted afterwards.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg
// Shared types for the systolic-array edge blocks.
//   sa_mode_e  : array operating mode (PRELOAD loads weights, COMPUTE streams psums)
//   psum_row_t : one aligned row of column psums for the default array geometry
package sa_pkg;

  typedef enum logic {
    SA_PRELOAD = 1'b0,
    SA_COMPUTE = 1'b1
  } sa_mode_e;

  localparam int SA_ADD_DATAWIDTH = 32;
  localparam int SA_NUM_COLS      = 4;

  typedef logic [SA_NUM_COLS-1:0][SA_ADD_DATAWIDTH-1:0] psum_row_t;

endpackage

// File: rtl/sa_psum_drain_if.sv
// sa_psum_drain_if
// Valid/ready stream carrying aligned psum rows out of the drain.
//   o_valid : drain has a row on o_data (driven by master)
//   o_data  : aligned row, lane c = column c (driven by master)
//   i_ready : consumer accepts the row when o_valid & i_ready (driven by slave)
interface sa_psum_drain_if #(
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_COLS      = 4
);
  logic                              o_valid;
  logic                              i_ready;
  logic [NUM_COLS*ADD_DATAWIDTH-1:0] o_data;

  modport master (output o_valid, output o_data, input i_ready);
  modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/sa_sync_fifo.sv
// sa_sync_fifo
// Single-clock FIFO holding aligned psum rows.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : synchronous flush, beats any push/pop in the same cycle
//   push_i     : write data_i (accepted when not full, or full with a pop)
//   pop_i      : drop head entry (ignored when empty)
//   data_o     : head entry, forced to zero while empty
//   full_o, empty_o, count_o : occupancy status
module sa_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = push_ok ? AW'(wr_q + 1'b1) : wr_q;
    rd_d  = pop_ok  ? AW'(rd_q + 1'b1) : rd_q;
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/sa_psum_drain.sv
// sa_psum_drain
// Bottom edge of the systolic array: captures the skewed column psums, aligns
// them into one row, buffers rows and hands them out over valid/ready. The
// array cannot stall, so a row that finds the buffer full is dropped and
// o_overflow latches.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_mode       : SA_PRELOAD ignores i_psum_valid, SA_COMPUTE launches rows
//   i_clear      : synchronous flush of deskew tags, FIFO and overflow flag
//   i_psum_valid : column-0 psum of a new row is on lane 0 this cycle
//   i_psum       : bottom-row psums, lane c = column c (column c lags by c cycles)
//   out_if       : aligned row stream (o_valid / o_data / i_ready)
//   o_count      : FIFO occupancy
//   o_overflow   : sticky, a completed row was dropped
module sa_psum_drain
  import sa_pkg::*;
#(
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_COLS      = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  sa_mode_e                          i_mode,
  input  logic                              i_clear,
  input  logic                              i_psum_valid,
  input  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum,
  sa_psum_drain_if.master                   out_if,
  output logic [$clog2(FIFO_DEPTH):0]       o_count,
  output logic                              o_overflow
);
  localparam int LW = ADD_DATAWIDTH;

  logic                   launch;
  logic [NUM_COLS-1:0]    en;     // en[c]: some row's tag sits at stage c this cycle
  logic [NUM_COLS*LW-1:0] row;
  logic                   push, pop, full, empty;
  logic                   overflow_q, overflow_d;

  assign launch = i_psum_valid && (i_mode == SA_COMPUTE);
  assign en[0]  = launch;

  // Tag pipeline: stage k holds the row launched k cycles ago.
  if (NUM_COLS > 1) begin : g_tag
    logic [NUM_COLS-1:1] tag_q, tag_d;

    assign tag_d            = en[NUM_COLS-2:0];
    assign en[NUM_COLS-1:1] = tag_q;

    always_ff @(posedge clk) begin
      if (!rst_n || i_clear) tag_q <= '0;
      else                   tag_q <= tag_d;
    end
  end

  // Lane c is sampled when the tag reaches stage c, then walks NUM_COLS-1-c
  // registers so it lines up with the last lane, which is used straight off
  // the input on the push cycle.
  for (genvar c = 0; c < NUM_COLS-1; c++) begin : g_lane
    logic [LW-1:0] dly_q [NUM_COLS-1-c];

    always_ff @(posedge clk) begin
      if (en[c]) dly_q[0] <= i_psum[c*LW +: LW];
      for (int j = 1; j < NUM_COLS-1-c; j++) begin
        if (en[c+j]) dly_q[j] <= dly_q[j-1];
      end
    end

    assign row[c*LW +: LW] = dly_q[NUM_COLS-2-c];
  end
  assign row[(NUM_COLS-1)*LW +: LW] = i_psum[(NUM_COLS-1)*LW +: LW];

  assign push = en[NUM_COLS-1] && !i_clear;
  // o_valid comes from FIFO state only, so i_ready never reaches it combinationally.
  assign pop  = out_if.o_valid && out_if.i_ready;

  sa_sync_fifo #(
    .WIDTH (NUM_COLS*LW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (i_clear),
    .push_i  (push),
    .data_i  (row),
    .pop_i   (pop),
    .data_o  (out_if.o_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (o_count)
  );

  assign out_if.o_valid = !empty;

  assign overflow_d = overflow_q || (push && full && !pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) overflow_q <= 1'b0;
    else                   overflow_q <= overflow_d;
  end

  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_sa_psum_drain.sv
module tb_sa_psum_drain;
  import sa_pkg::*;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  sa_mode_e              mode;
  logic                  clear;
  logic                  pv;
  logic [N*W-1:0]        psum;
  logic [$clog2(D):0]    count;
  logic                  ovf;

  always #5 clk = ~clk;

  sa_psum_drain_if #(.ADD_DATAWIDTH(W), .NUM_COLS(N)) bus ();

  sa_psum_drain #(
    .ADD_DATAWIDTH (W),
    .NUM_COLS      (N),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_mode       (mode),
    .i_clear      (clear),
    .i_psum_valid (pv),
    .i_psum       (psum),
    .out_if       (bus.master),
    .o_count      (count),
    .o_overflow   (ovf)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // launch schedule: row m launches at l_cyc[m], lane c appears at l_cyc[m]+c
  int         n_rows;
  int         l_cyc [16];
  logic [W-1:0] l_dat [16][N];
  logic       force_pv;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic add_row(input int at, input logic [W-1:0] base);
    l_cyc[n_rows] = at;
    for (int c = 0; c < N; c++) l_dat[n_rows][c] = base + W'(c);
    n_rows++;
  endtask

  function automatic logic [N*W-1:0] row_of(input logic [W-1:0] base);
    logic [N*W-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = base + W'(c);
    return r;
  endfunction

  task automatic drive();
    pv = force_pv;
    for (int m = 0; m < n_rows; m++) if (l_cyc[m] == cyc) pv = 1'b1;
    for (int c = 0; c < N; c++) begin
      psum[c*W +: W] = 32'hBAD0_0000 + W'(c);
      for (int m = 0; m < n_rows; m++)
        if (l_cyc[m] + c == cyc) psum[c*W +: W] = l_dat[m][c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic flush_test(input bit use_rst);
    int t, cc;
    string nm;
    nm = use_rst ? "t6r" : "t6c";
    bus.i_ready = 1'b0;
    n_rows = 0;
    t = cyc + 2;
    add_row(t,     32'h600);
    add_row(t + 1, 32'h610);
    add_row(t + 3, 32'h620);
    add_row(t + 4, 32'h630);
    cc = t + 6;
    while (cyc < cc) begin
      drive();
      tick();
    end
    drive();
    check_eq({nm, "_pre_count"}, count, 2);
    if (use_rst) rst_n = 1'b0;
    else         clear = 1'b1;
    tick();
    rst_n = 1'b1;
    clear = 1'b0;
    drive();
    check_eq({nm, "_count"}, count, 0);
    check_eq({nm, "_valid"}, bus.o_valid, 0);
    check_eq({nm, "_ovf"},   ovf, 0);
    check_eq({nm, "_data"},  bus.o_data, 0);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive();
      check_eq({nm, "_stale"}, bus.o_valid, 0);
      tick();
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    mode = SA_COMPUTE;
    clear = 1'b0;
    bus.i_ready = 1'b0;
    force_pv = 1'b0;
    n_rows = 0;
    drive();
    repeat (3) tick();
    check_eq("rst_valid", bus.o_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ovf",   ovf, 0);
    check_eq("rst_data",  bus.o_data, 0);
    rst_n = 1'b1;

    // 1: single row
    n_rows = 0;
    t = cyc;
    add_row(t + 10, 32'h100);
    bus.i_ready = 1'b1;
    while (cyc <= t + 16) begin
      drive();
      check_eq("t1_valid", bus.o_valid, (cyc == t + 14));
      if (cyc == t + 14)
        check_eq("t1_data", bus.o_data, 128'h00000103_00000102_00000101_00000100);
      tick();
    end

    // 2: streaming, eight back-to-back rows
    n_rows = 0;
    t = cyc + 2;
    for (int m = 0; m < 8; m++) add_row(t + m, W'(16 * m));
    while (cyc <= t + 13) begin
      drive();
      check_eq("t2_valid", bus.o_valid, (cyc >= t + 4 && cyc <= t + 11));
      if (cyc >= t + 4 && cyc <= t + 11)
        check_eq("t2_data", bus.o_data, row_of(W'(16 * (cyc - t - 4))));
      tick();
    end
    check_eq("t2_ovf",   ovf, 0);
    check_eq("t2_count", count, 0);

    // 3: backpressure, fifth row dropped
    bus.i_ready = 1'b0;
    n_rows = 0;
    t = cyc + 2;
    for (int m = 0; m < 5; m++) add_row(t + m, W'(32'h300 + 16 * m));
    while (cyc < t + 10) begin
      drive();
      tick();
    end
    drive();
    check_eq("t3_count", count, 4);
    check_eq("t3_ovf",   ovf, 1);
    check_eq("t3_hold",  bus.o_data, row_of(32'h300));
    bus.i_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive();
      check_eq("t3_valid", bus.o_valid, 1);
      check_eq("t3_data",  bus.o_data, row_of(W'(32'h300 + 16 * m)));
      tick();
    end
    drive();
    check_eq("t3_empty", bus.o_valid, 0);
    check_eq("t3_ovf_sticky", ovf, 1);

    // 4: full FIFO with simultaneous push and pop
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive();
    check_eq("t4_clr_ovf",   ovf, 0);
    check_eq("t4_clr_count", count, 0);
    n_rows = 0;
    t = cyc + 2;
    for (int m = 0; m < 4; m++) add_row(t + m, W'(32'h400 + 16 * m));
    add_row(t + 5, 32'h440);
    while (cyc < t + 9) begin
      drive();
      bus.i_ready = (cyc == t + 8);
      if (cyc == t + 7) check_eq("t4_full", count, 4);
      if (cyc == t + 8) check_eq("t4_head", bus.o_data, row_of(32'h400));
      tick();
    end
    bus.i_ready = 1'b0;
    drive();
    check_eq("t4_count", count, 4);
    check_eq("t4_ovf",   ovf, 0);
    bus.i_ready = 1'b1;
    for (int m = 1; m < 5; m++) begin
      drive();
      check_eq("t4_valid", bus.o_valid, 1);
      check_eq("t4_data",  bus.o_data, row_of(W'(32'h400 + 16 * m)));
      tick();
    end
    drive();
    check_eq("t4_empty", bus.o_valid, 0);

    // 5: i_psum_valid ignored in PRELOAD
    n_rows = 0;
    mode = SA_PRELOAD;
    force_pv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive();
      check_eq("t5_valid", bus.o_valid, 0);
      tick();
    end
    mode = SA_COMPUTE;
    force_pv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive();
      check_eq("t5_valid_after", bus.o_valid, 0);
      check_eq("t5_count", count, 0);
      tick();
    end

    // 6: flush with rows queued and in flight
    flush_test(1'b0);
    flush_test(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
